// File: rtl/tick_gen.sv
// tick_gen: one-cycle enable pulses for the T-flip-flop counter, either
// free-running at a switch-selected rate or one per debounced button press.
//
// Ports:
//   clock     system clock, rising edge
//   Resetn    asynchronous active-low reset
//   rate_sel  period select: 00 N=1, 01 N=DIV_FULL, 10 N=2*DIV_FULL,
//             11 N=4*DIV_FULL
//   run       1 free-running ticks, 0 single-step via step_n
//   step_n    raw active-low pushbutton, asynchronous and bouncy
//   tick      registered one-cycle enable pulse
//   pressed   debounced button level, 1 = held
module tick_gen #(
   parameter int DIV_FULL = 50_000_000,
   parameter int DEBOUNCE = 500_000
) (
   input  logic       clock,
   input  logic       Resetn,
   input  logic [1:0] rate_sel,
   input  logic       run,
   input  logic       step_n,
   output logic       tick,
   output logic       pressed
);

   localparam int CW = $clog2(4 * DIV_FULL);
   localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

   localparam logic [CW-1:0] LAST1 = CW'(DIV_FULL - 1);
   localparam logic [CW-1:0] LAST2 = CW'(2 * DIV_FULL - 1);
   localparam logic [CW-1:0] LAST4 = CW'(4 * DIV_FULL - 1);
   localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE - 1);

   logic          s1;
   logic          s2;
   logic          db;
   logic [DW-1:0] dcnt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] last;
   logic [1:0]    prev_sel;
   logic          step_pulse;

   // Asserted only in the cycle the debounced level falls (press accepted).
   assign step_pulse = db && !s2 && (dcnt == DLAST);

   always_comb begin
      last = '0;
      unique case (rate_sel)
         2'b00:   last = '0;
         2'b01:   last = LAST1;
         2'b10:   last = LAST2;
         default: last = LAST4;
      endcase
   end

   // Synchronizer and debouncer; idle level of the button is 1.
   always_ff @(posedge clock or negedge Resetn) begin
      if (!Resetn) begin
         s1      <= 1'b1;
         s2      <= 1'b1;
         db      <= 1'b1;
         dcnt    <= '0;
         pressed <= 1'b0;
      end else begin
         s1 <= step_n;
         s2 <= s1;
         if (s2 == db) begin
            dcnt <= '0;
         end else if (dcnt == DLAST) begin
            db      <= s2;
            pressed <= ~s2;
            dcnt    <= '0;
         end else begin
            dcnt <= dcnt + DW'(1);
         end
      end
   end

   // Divider and tick; a rate change wins over everything so the new
   // period always starts from a clean count.
   always_ff @(posedge clock or negedge Resetn) begin
      if (!Resetn) begin
         cnt      <= '0;
         tick     <= 1'b0;
         prev_sel <= 2'b00;
      end else begin
         prev_sel <= rate_sel;
         if (rate_sel != prev_sel) begin
            cnt  <= '0;
            tick <= 1'b0;
         end else if (!run) begin
            cnt  <= '0;
            tick <= step_pulse;
         end else if (cnt == last) begin
            cnt  <= '0;
            tick <= 1'b1;
         end else begin
            cnt  <= cnt + CW'(1);
            tick <= 1'b0;
         end
      end
   end

endmodule
